// File: rtl/board_adapter.sv
// Board-side adapter: pixel clock-enable divider, key sync/debounce/press latch,
// and a registered video output stage with sync polarity and colour expansion.
module board_adapter #(
    parameter int unsigned DIV         = 2,
    parameter int unsigned NKEYS       = 4,
    parameter int unsigned KEY_ACT_LOW = 0,
    parameter int unsigned DEB_W       = 16,
    parameter int unsigned CH_IN_W     = 1,
    parameter int unsigned CH_W        = 4,
    parameter int unsigned HS_INV      = 0,
    parameter int unsigned VS_INV      = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NKEYS-1:0]       keys,
    output logic                   core_ce,
    output logic [NKEYS-1:0]       core_keys,
    output logic [NKEYS-1:0]       core_key_press,
    input  logic                   core_hsync,
    input  logic                   core_vsync,
    input  logic [3*CH_IN_W-1:0]   core_rgb,
    output logic                   vga_hsync,
    output logic                   vga_vsync,
    output logic [CH_W-1:0]        vga_r,
    output logic [CH_W-1:0]        vga_g,
    output logic [CH_W-1:0]        vga_b
);

    localparam int unsigned      CW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]    CNT_LAST = CW'(DIV - 1);
    localparam logic [DEB_W-1:0] DEB_MAX  = '1;
    localparam logic [NKEYS-1:0] KEY_XOR  = (KEY_ACT_LOW != 0) ? '1 : '0;
    localparam logic             HS_POL   = (HS_INV != 0);
    localparam logic             VS_POL   = (VS_INV != 0);

    logic [CW-1:0]      cnt_q, cnt_d;
    logic               ce_q, ce_d;
    logic [NKEYS-1:0]   s1_q, s1_d;
    logic [NKEYS-1:0]   s2_q, s2_d;
    logic [NKEYS-1:0]   stable_q, stable_d;
    logic [DEB_W-1:0]   dcnt_q [NKEYS];
    logic [DEB_W-1:0]   dcnt_d [NKEYS];
    logic [NKEYS-1:0]   press_q, press_d;
    logic               hs_q, hs_d;
    logic               vs_q, vs_d;
    logic [3*CH_W-1:0]  rgb_q, rgb_d;

    always_comb begin
        cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        ce_d  = (cnt_q == CNT_LAST);

        s1_d = keys ^ KEY_XOR;
        s2_d = s1_q;

        stable_d = stable_q;
        for (int unsigned i = 0; i < NKEYS; i++) begin
            dcnt_d[i] = '0;
            if (s2_q[i] != stable_q[i]) begin
                if (dcnt_q[i] == DEB_MAX) begin
                    stable_d[i] = s2_q[i];
                end else begin
                    dcnt_d[i] = dcnt_q[i] + 1'b1;
                end
            end
        end

        // A rising debounced level sets the latch even on a consuming core_ce edge.
        press_d = (stable_d & ~stable_q) | (press_q & ~{NKEYS{ce_q}});

        hs_d = core_hsync ^ HS_POL;
        vs_d = core_vsync ^ VS_POL;

        // MSB-first repetition: output bit b takes the input bit at the same
        // position modulo CH_IN_W, counted from the MSB end.
        rgb_d = '0;
        for (int unsigned c = 0; c < 3; c++) begin
            for (int unsigned b = 0; b < CH_W; b++) begin
                rgb_d[c*CH_W + b] =
                    core_rgb[c*CH_IN_W + CH_IN_W - 1 - ((CH_W - 1 - b) % CH_IN_W)];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            ce_q     <= 1'b0;
            s1_q     <= '0;
            s2_q     <= '0;
            stable_q <= '0;
            for (int unsigned i = 0; i < NKEYS; i++) begin
                dcnt_q[i] <= '0;
            end
            press_q  <= '0;
            hs_q     <= HS_POL;
            vs_q     <= VS_POL;
            rgb_q    <= '0;
        end else begin
            cnt_q    <= cnt_d;
            ce_q     <= ce_d;
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            stable_q <= stable_d;
            for (int unsigned i = 0; i < NKEYS; i++) begin
                dcnt_q[i] <= dcnt_d[i];
            end
            press_q  <= press_d;
            hs_q     <= hs_d;
            vs_q     <= vs_d;
            rgb_q    <= rgb_d;
        end
    end

    assign core_ce        = ce_q;
    assign core_keys      = stable_q;
    assign core_key_press = press_q;
    assign vga_hsync      = hs_q;
    assign vga_vsync      = vs_q;
    assign vga_r          = rgb_q[CH_W-1:0];
    assign vga_g          = rgb_q[2*CH_W-1:CH_W];
    assign vga_b          = rgb_q[3*CH_W-1:2*CH_W];

endmodule

// File: tb/tb_board_adapter.sv
// Scoreboard bench for board_adapter: two configurations (DIV=3 active-high keys,
// DIV=1 active-low keys) driven together and checked against an edge-history model.
module tb_board_adapter;

    localparam int DEB_MAX = 15;
    localparam int MAXE    = 8191;

    typedef struct packed {
        logic       ce0;
        logic [3:0] k0;
        logic [3:0] p0;
        logic       hs0;
        logic       vs0;
        logic [4:0] r0;
        logic [4:0] g0;
        logic [4:0] b0;
        logic       ce1;
        logic [3:0] k1;
        logic [3:0] p1;
        logic       hs1;
        logic       vs1;
        logic [3:0] r1;
        logic [3:0] g1;
        logic [3:0] b1;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] keys = '0;
    logic       core_hsync = 1'b0;
    logic       core_vsync = 1'b0;
    logic [5:0] core_rgb = '0;

    logic       ce0, hs0, vs0, ce1, hs1, vs1;
    logic [3:0] keys0, press0, keys1, press1;
    logic [4:0] r0, g0, b0;
    logic [3:0] r1, g1, b1;

    board_adapter #(
        .DIV(3), .NKEYS(4), .KEY_ACT_LOW(0), .DEB_W(4),
        .CH_IN_W(2), .CH_W(5), .HS_INV(1), .VS_INV(0)
    ) dut0 (
        .clk(clk), .reset(reset), .keys(keys),
        .core_ce(ce0), .core_keys(keys0), .core_key_press(press0),
        .core_hsync(core_hsync), .core_vsync(core_vsync), .core_rgb(core_rgb),
        .vga_hsync(hs0), .vga_vsync(vs0), .vga_r(r0), .vga_g(g0), .vga_b(b0)
    );

    board_adapter #(
        .DIV(1), .NKEYS(4), .KEY_ACT_LOW(1), .DEB_W(4),
        .CH_IN_W(1), .CH_W(4), .HS_INV(0), .VS_INV(1)
    ) dut1 (
        .clk(clk), .reset(reset), .keys(keys),
        .core_ce(ce1), .core_keys(keys1), .core_key_press(press1),
        .core_hsync(core_hsync), .core_vsync(core_vsync), .core_rgb(core_rgb[2:0]),
        .vga_hsync(hs1), .vga_vsync(vs1), .vga_r(r1), .vga_g(g1), .vga_b(b1)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    logic mon_en = 1'b0;
    exp_t exp_q[$];

    // Reference model: edges since reset, raw key samples per edge, debounced state.
    int         e = 0;
    logic [3:0] raw_hist [0:MAXE];
    logic [3:0] stab  [2];
    logic [3:0] press [2];
    int         last_flip [2][4];

    function automatic logic view(input int u, input int j, input int i);
        logic v;
        if (j < 3) return 1'b0;
        v = raw_hist[j-2][i];
        return (u == 1) ? ~v : v;
    endfunction

    function automatic logic [7:0] expand(input int unsigned v, input int unsigned win,
                                          input int unsigned wout);
        int unsigned rep = 0;
        int unsigned n = 0;
        while (n * win < wout) begin
            rep = (rep << win) | v;
            n++;
        end
        return 8'(rep >> (n * win - wout));
    endfunction

    task automatic model_reset();
        e = 0;
        for (int u = 0; u < 2; u++) begin
            stab[u]  = '0;
            press[u] = '0;
            for (int i = 0; i < 4; i++) last_flip[u][i] = 0;
        end
    endtask

    function automatic exp_t reset_exp();
        exp_t x = '0;
        x.hs0 = 1'b1;
        x.vs1 = 1'b1;
        return x;
    endfunction

    task automatic model_edge(output exp_t x);
        int  divu;
        logic ce_prev, all_diff, set;
        e++;
        raw_hist[e] = keys;
        for (int u = 0; u < 2; u++) begin
            divu    = (u == 0) ? 3 : 1;
            ce_prev = (e - 1 >= 1) && (((e - 1) % divu) == 0);
            for (int i = 0; i < 4; i++) begin
                set = 1'b0;
                // New level accepted after DEB_MAX+1 consecutive disagreeing samples.
                if (e - last_flip[u][i] >= DEB_MAX + 1) begin
                    all_diff = 1'b1;
                    for (int j = e - DEB_MAX; j <= e; j++)
                        if (view(u, j, i) == stab[u][i]) all_diff = 1'b0;
                    if (all_diff) begin
                        stab[u][i] = ~stab[u][i];
                        last_flip[u][i] = e;
                        set = stab[u][i];
                    end
                end
                press[u][i] = set | (press[u][i] & ~ce_prev);
            end
        end
        x.ce0 = (e % 3) == 0;
        x.k0  = stab[0];
        x.p0  = press[0];
        x.hs0 = ~core_hsync;
        x.vs0 = core_vsync;
        x.r0  = 5'(expand(core_rgb[1:0], 2, 5));
        x.g0  = 5'(expand(core_rgb[3:2], 2, 5));
        x.b0  = 5'(expand(core_rgb[5:4], 2, 5));
        x.ce1 = 1'b1;
        x.k1  = stab[1];
        x.p1  = press[1];
        x.hs1 = core_hsync;
        x.vs1 = ~core_vsync;
        x.r1  = 4'(expand(core_rgb[0], 1, 4));
        x.g1  = 4'(expand(core_rgb[1], 1, 4));
        x.b1  = 4'(expand(core_rgb[2], 1, 4));
    endtask

    // One driver step between a falling edge and the next DUT event.
    task automatic step(input logic rst_v, input logic [3:0] k_v);
        exp_t x;
        @(negedge clk);
        core_hsync = 1'($urandom);
        core_vsync = 1'($urandom);
        core_rgb   = 6'($urandom);
        keys       = k_v;
        if (rst_v) begin
            model_reset();
            exp_q.push_back(reset_exp());
            if (!reset) exp_q.push_back(reset_exp());
            mon_en = 1'b1;
            reset  = 1'b1;
        end else begin
            reset = 1'b0;
            model_edge(x);
            exp_q.push_back(x);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
        end
    endtask

    initial begin : monitor
        exp_t x;
        wait (mon_en);
        forever begin
            @(posedge clk or posedge reset);
            #1;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL scoreboard_underflow at %0t: got empty queue expected entry", $time);
            end else begin
                x = exp_q.pop_front();
                chk("ce_div3",    32'(ce0),    32'(x.ce0));
                chk("keys_div3",  32'(keys0),  32'(x.k0));
                chk("press_div3", 32'(press0), 32'(x.p0));
                chk("hsync_inv",  32'(hs0),    32'(x.hs0));
                chk("vsync",      32'(vs0),    32'(x.vs0));
                chk("r_2to5",     32'(r0),     32'(x.r0));
                chk("g_2to5",     32'(g0),     32'(x.g0));
                chk("b_2to5",     32'(b0),     32'(x.b0));
                chk("ce_div1",    32'(ce1),    32'(x.ce1));
                chk("keys_low",   32'(keys1),  32'(x.k1));
                chk("press_low",  32'(press1), 32'(x.p1));
                chk("hsync",      32'(hs1),    32'(x.hs1));
                chk("vsync_inv",  32'(vs1),    32'(x.vs1));
                chk("r_1to4",     32'(r1),     32'(x.r1));
                chk("g_1to4",     32'(g1),     32'(x.g1));
                chk("b_1to4",     32'(b1),     32'(x.b1));
            end
        end
    end

    initial begin : driver
        logic [3:0] pat = '0;
        int         len;
        model_reset();
        repeat (3) step(1'b1, 4'b0000);

        repeat (30) step(1'b0, 4'b0100);
        repeat (30) step(1'b0, 4'b0000);

        repeat (10) step(1'b0, 4'b0001);
        repeat (25) step(1'b0, 4'b0000);

        for (int s = 0; s < 70; s++) begin
            pat = pat ^ 4'($urandom_range(1, 15));
            len = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 14) : $urandom_range(17, 40);
            repeat (len) step(1'b0, pat);
        end

        repeat (25) step(1'b0, 4'b0000);
        repeat (8)  step(1'b0, 4'b0010);
        repeat (10) step(1'b0, 4'b1010);
        repeat (3)  step(1'b1, 4'b1010);
        repeat (25) step(1'b0, 4'b1010);
        repeat (5)  step(1'b0, 4'b0000);

        @(negedge clk);
        chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #400000;
        bad++;
        $display("FAIL timeout at %0t: got no completion expected finish", $time);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/board_adapter.md
# board_adapter

Parametrised board-side adapter between a video-game core and the FPGA board pins. It generates the core's pixel-rate clock enable from the board clock with a divide-by-DIV counter, and synchronises, debounces and edge-latches the raw push-button inputs. It also registers the core's sync and colour outputs, applying sync polarity and bit-replicated colour-depth expansion. It sits between the top-level pins and any game core, with the whole design on a single clock.

## Interface
- DIV, 2: board clocks per core clock-enable; legal range 1..256.
- NKEYS, 4: number of push buttons.
- KEY_ACT_LOW, 0: 1 = raw keys are active-low.
- DEB_W, 16: debounce counter width; DEB_MAX = 2^DEB_W-1.
- CH_IN_W, 1: core colour bits per channel.
- CH_W, 4: board colour bits per channel; CH_W >= CH_IN_W.
- HS_INV, 0 / VS_INV, 0: 1 = invert hsync / vsync toward the board.

Ports:
- clk  in  1  board clock.
- reset  in  1  asynchronous, active-high; clock clk.
- keys  in  NKEYS  raw, asynchronous button inputs.
- core_ce  out  1  one-clk-wide enable pulse every DIV clocks.
- core_keys  out  NKEYS  debounced key levels, active-high.
- core_key_press  out  NKEYS  press latches, held until consumed by core_ce.
- core_hsync, core_vsync  in  1  core sync outputs, active-high.
- core_rgb  in  3*CH_IN_W  packed {B,G,R}, with R in the LSBs.
- vga_hsync, vga_vsync  out  1  registered sync outputs, polarity applied.
- vga_r, vga_g, vga_b  out  CH_W  registered, expanded colour channels.

## Operation
- Clock enable:
  - Counter cnt, width clog2(DIV) (min 1), counts 0..DIV-1 and wraps.
  - core_ce is registered: core_ce <= (cnt == DIV-1).
  - DIV=1: core_ce is constantly 1 from the first edge after reset.
- Key normalisation: k = keys ^ {NKEYS{KEY_ACT_LOW}}.
- Synchroniser: two flops per key, s1 <= k, s2 <= s1.
- Debounce, per key, registers stable and dcnt[DEB_W]:
  - s2 == stable: dcnt <= 0.
  - s2 != stable and dcnt != DEB_MAX: dcnt <= dcnt+1.
  - s2 != stable and dcnt == DEB_MAX: stable <= s2, dcnt <= 0.
  - Any return to equality before DEB_MAX is reached discards the change (glitch rejected).
  - core_keys = stable.
- Press latch, per key:
  - Set on the edge where stable goes 0->1.
  - Cleared on any edge where core_ce == 1.
  - A set and a clear on the same edge: set wins.
  - Release (1->0) never sets the latch.
- Video path, one register stage:
  - vga_hsync <= core_hsync ^ HS_INV; vga_vsync <= core_vsync ^ VS_INV.
  - Each CH_IN_W channel field is expanded to CH_W bits by MSB-first repetition, truncated to CH_W.
  - Expansion maps 0 to 0 and all-ones to all-ones.
  - Example CH_IN_W=1, CH_W=4: 1 -> 4'hF.
  - Example CH_IN_W=2, CH_W=4: 2'b10 -> 4'b1010.

## Timing
- Reset values:
  - core_ce=0, cnt=0, s1=s2=0, stable=0, dcnt=0, core_key_press=0.
  - vga_hsync=HS_INV, vga_vsync=VS_INV, vga_r/g/b=0.
- core_ce after reset release:
  - First high on rising edge DIV, then every DIV edges.
  - Duty is 1 clk, except DIV=1, where it is constant high.
- Key latency:
  - A normalised key change held steady before edge 1 appears on core_keys after edge 3+DEB_MAX.
  - Example DEB_W=4: edge 18.
- core_key_press rises on the same edge as core_keys.
- Video latency is 1 clk, independent of core_ce; outputs update every clk.
- Reset mid-operation: every register returns to its reset value asynchronously, including any in-progress debounce count and pending press latch.
- No output glitches combinationally: all outputs are registered.

## Test plan
- DIV=3: release reset, count edges -> core_ce high on edges 3, 6, 9, ... (exactly 1 clk each); DIV=1 -> high from edge 1 onward.
- DEB_W=4, KEY_ACT_LOW=0: keys[2] 0->1 and held -> core_keys[2]=1 at edge 18, core_key_press[2]=1 at edge 18, other bits stay 0.
- DEB_W=4: keys[0] pulse 10 clks high, then low -> core_keys[0] and core_key_press[0] never assert; release after a valid press -> core_keys falls at 3+15 edges and the press latch is not re-set.
- DIV=4: press latch set, then the next core_ce edge -> latch clears on that edge; press completing on the same edge as core_ce -> latch stays 1 until the following core_ce.
- HS_INV=1, VS_INV=0, CH_IN_W=1, CH_W=4: core_rgb=3'b101, hsync=0, vsync=1 -> one clk later vga_r=4'hF, vga_g=0, vga_b=4'hF, vga_hsync=1, vga_vsync=1.
- Assert reset mid-debounce (dcnt=7) and with a latched press -> all outputs take reset values immediately; after release the key needs the full 18 edges again.
